// File: rtl/branch_predict_resolve_unit_if.sv
// EX-stage resolution bus of the branch predict/resolve unit.
// The IF-stage prediction lookup is carried here as well.
interface branch_predict_resolve_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [31:0]           PC_IF;
    logic                  PRED_TAKEN;
    logic                  VALID_EX;
    logic                  STALL;
    logic [31:0]           PC_EX;
    logic [DATA_WIDTH-1:0] DATA1;
    logic [DATA_WIDTH-1:0] DATA2;
    logic [3:0]            SELECT;
    logic                  PRED_TAKEN_EX;
    logic                  BJ_SIG;
    logic                  MISPREDICT;
    logic [CNT_WIDTH-1:0]  BR_COUNT;
    logic [CNT_WIDTH-1:0]  MISS_COUNT;

    modport master (
        output PC_IF, VALID_EX, STALL, PC_EX, DATA1, DATA2, SELECT, PRED_TAKEN_EX,
        input  PRED_TAKEN, BJ_SIG, MISPREDICT, BR_COUNT, MISS_COUNT
    );

    modport slave (
        input  PC_IF, VALID_EX, STALL, PC_EX, DATA1, DATA2, SELECT, PRED_TAKEN_EX,
        output PRED_TAKEN, BJ_SIG, MISPREDICT, BR_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/branch_predict_resolve_unit.sv
// Branch resolution unit with a bimodal 2-bit BHT, registered taken/mispredict
// pulses and saturating branch/miss performance counters.
module branch_predict_resolve_unit #(
    parameter int         DATA_WIDTH = 32,
    parameter int         BHT_DEPTH  = 64,
    parameter int         CNT_WIDTH  = 16,
    parameter logic [1:0] BHT_INIT   = 2'b01
) (
    input logic                          CLK,
    input logic                          RESET,
    branch_predict_resolve_unit_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        F_EQ   = 3'b000,
        F_NE   = 3'b001,
        F_JUMP = 3'b010,
        F_NONE = 3'b011,
        F_LT   = 3'b100,
        F_GE   = 3'b101,
        F_LTU  = 3'b110,
        F_GEU  = 3'b111
    } funct3_e;

    logic [1:0]           bht [BHT_DEPTH];
    logic [IDX_W-1:0]     idx_if;
    logic [IDX_W-1:0]     idx_ex;
    logic [1:0]           bht_ex;
    funct3_e              funct3;
    logic                 taken;
    logic                 is_cond_op;
    logic                 ex_event;
    logic                 cond;
    logic                 dir_wrong;
    logic                 bj_sig_q;
    logic                 mispredict_q;
    logic [CNT_WIDTH-1:0] br_count_q;
    logic [CNT_WIDTH-1:0] miss_count_q;
    logic                 unused_pc;

    assign idx_if    = bus.PC_IF[IDX_W+1:2];
    assign idx_ex    = bus.PC_EX[IDX_W+1:2];
    assign bht_ex    = bht[idx_ex];
    assign unused_pc = ^{bus.PC_IF[31:IDX_W+2], bus.PC_IF[1:0],
                         bus.PC_EX[31:IDX_W+2], bus.PC_EX[1:0]};

    // Combinational read of the registered table: a same-cycle write to this
    // index is only visible after the edge.
    assign bus.PRED_TAKEN = bht[idx_if][1];

    assign funct3 = funct3_e'(bus.SELECT[2:0]);

    always_comb begin
        taken      = 1'b0;
        is_cond_op = 1'b1;
        unique case (funct3)
            F_EQ:   taken = (bus.DATA1 == bus.DATA2);
            F_NE:   taken = (bus.DATA1 != bus.DATA2);
            F_LT:   taken = ($signed(bus.DATA1) <  $signed(bus.DATA2));
            F_GE:   taken = ($signed(bus.DATA1) >= $signed(bus.DATA2));
            F_LTU:  taken = (bus.DATA1 <  bus.DATA2);
            F_GEU:  taken = (bus.DATA1 >= bus.DATA2);
            F_JUMP: begin
                taken      = 1'b1;
                is_cond_op = 1'b0;
            end
            F_NONE: begin
                taken      = 1'b0;
                is_cond_op = 1'b0;
            end
            default: begin
                taken      = 1'b0;
                is_cond_op = 1'b0;
            end
        endcase
    end

    assign ex_event  = bus.VALID_EX & bus.SELECT[3] & ~bus.STALL;
    assign cond      = ex_event & is_cond_op;
    assign dir_wrong = (taken != bus.PRED_TAKEN_EX);

    // Outputs are one-shot pulses: any non-event cycle (including stall) clears them.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bj_sig_q     <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            bj_sig_q     <= ex_event & taken;
            mispredict_q <= cond & dir_wrong;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else if (cond) begin
            if (br_count_q != '1) begin
                br_count_q <= br_count_q + 1'b1;
            end
            if (dir_wrong && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (cond) begin
            if (taken && (bht_ex != 2'b11)) begin
                bht[idx_ex] <= bht_ex + 2'd1;
            end else if (!taken && (bht_ex != 2'b00)) begin
                bht[idx_ex] <= bht_ex - 2'd1;
            end
        end
    end

    assign bus.BJ_SIG     = bj_sig_q;
    assign bus.MISPREDICT = mispredict_q;
    assign bus.BR_COUNT   = br_count_q;
    assign bus.MISS_COUNT = miss_count_q;

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Scoreboard bench: two instances (16-bit and 4-bit counters) share one stimulus
// stream and are compared against a behavioural model of the predictor.
module tb_branch_predict_resolve_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_resolve_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus16 ();
    branch_predict_resolve_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

    branch_predict_resolve_unit #(
        .DATA_WIDTH(32), .BHT_DEPTH(64), .CNT_WIDTH(16), .BHT_INIT(2'b01)
    ) dut16 (.CLK(clk), .RESET(rst_n), .bus(bus16));

    branch_predict_resolve_unit #(
        .DATA_WIDTH(32), .BHT_DEPTH(64), .CNT_WIDTH(4), .BHT_INIT(2'b01)
    ) dut4 (.CLK(clk), .RESET(rst_n), .bus(bus4));

    typedef struct {
        bit bj;
        bit mis;
        int br16;
        int miss16;
        int br4;
        int miss4;
        bit pred;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: plain integer counters, clamped arithmetic.
    int bht_m[64];
    int br16_m, miss16_m, br4_m, miss4_m;

    localparam logic [3:0] BEQ  = 4'b1000;
    localparam logic [3:0] BNE  = 4'b1001;
    localparam logic [3:0] JAL  = 4'b1010;
    localparam logic [3:0] BLT  = 4'b1100;
    localparam logic [3:0] BLTU = 4'b1110;
    localparam logic [3:0] BGEU = 4'b1111;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        br16_m = 0; miss16_m = 0; br4_m = 0; miss4_m = 0;
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit model_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return 1'b1;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit valid, input bit stall, input logic [31:0] pc_ex,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [3:0] sel, input bit pex, input logic [31:0] pc_if);
        bus16.VALID_EX = valid;  bus4.VALID_EX = valid;
        bus16.STALL = stall;     bus4.STALL = stall;
        bus16.PC_EX = pc_ex;     bus4.PC_EX = pc_ex;
        bus16.DATA1 = d1;        bus4.DATA1 = d1;
        bus16.DATA2 = d2;        bus4.DATA2 = d2;
        bus16.SELECT = sel;      bus4.SELECT = sel;
        bus16.PRED_TAKEN_EX = pex; bus4.PRED_TAKEN_EX = pex;
        bus16.PC_IF = pc_if;     bus4.PC_IF = pc_if;
    endtask

    // One EX-stage cycle: drive at the falling edge, predict the post-edge state.
    task automatic issue(input bit valid, input bit stall, input logic [31:0] pc_ex,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [3:0] sel, input bit pex, input logic [31:0] pc_if);
        exp_t e;
        bit   ev, cnd, tk;
        int   ix;
        @(negedge clk);
        drive(valid, stall, pc_ex, d1, d2, sel, pex, pc_if);
        ev  = valid && sel[3] && !stall;
        tk  = model_taken(sel[2:0], d1, d2);
        cnd = ev && (sel[2:0] != 3'd2) && (sel[2:0] != 3'd3);
        e.bj  = ev && tk;
        e.mis = cnd && (tk != pex);
        if (cnd) begin
            ix = idx_of(pc_ex);
            bht_m[ix] = tk ? ((bht_m[ix] < 3) ? bht_m[ix] + 1 : 3)
                           : ((bht_m[ix] > 0) ? bht_m[ix] - 1 : 0);
            br16_m = (br16_m < 65535) ? br16_m + 1 : 65535;
            br4_m  = (br4_m < 15) ? br4_m + 1 : 15;
            if (tk != pex) begin
                miss16_m = (miss16_m < 65535) ? miss16_m + 1 : 65535;
                miss4_m  = (miss4_m < 15) ? miss4_m + 1 : 15;
            end
        end
        e.br16 = br16_m; e.miss16 = miss16_m;
        e.br4  = br4_m;  e.miss4  = miss4_m;
        e.pred = (bht_m[idx_of(pc_if)] >= 2);
        sbq.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_bj"},    bus16.BJ_SIG, 0);
        chk({tag, "_mis"},   bus16.MISPREDICT, 0);
        chk({tag, "_br16"},  bus16.BR_COUNT, 0);
        chk({tag, "_miss16"}, bus16.MISS_COUNT, 0);
        chk({tag, "_br4"},   bus4.BR_COUNT, 0);
        chk({tag, "_miss4"}, bus4.MISS_COUNT, 0);
        chk({tag, "_pred"},  bus16.PRED_TAKEN, 0);
        chk({tag, "_pred4"}, bus4.PRED_TAKEN, 0);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("bj_sig",     bus16.BJ_SIG,     e.bj);
            chk("mispredict", bus16.MISPREDICT, e.mis);
            chk("br_count",   bus16.BR_COUNT,   e.br16);
            chk("miss_count", bus16.MISS_COUNT, e.miss16);
            chk("pred_taken", bus16.PRED_TAKEN, e.pred);
            chk("bj_sig4",    bus4.BJ_SIG,      e.bj);
            chk("mispredict4", bus4.MISPREDICT, e.mis);
            chk("br_count4",  bus4.BR_COUNT,    e.br4);
            chk("miss_count4", bus4.MISS_COUNT, e.miss4);
        end
    end

    initial begin
        logic [31:0] d1, d2, pe, pi;
        logic [3:0]  sel;
        int          wait_cnt;

        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h40);
        model_reset();
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Taken BEQ predicted not-taken: mispredict, entry 01 -> 10.
        issue(1, 0, 32'h100, 32'd5, 32'd5, BEQ, 0, 32'h100);
        // Signed vs unsigned compares on the same operands.
        issue(1, 0, 32'h104, 32'hFFFF_FFFF, 32'd1, BLT,  1, 32'h104);
        issue(1, 0, 32'h108, 32'hFFFF_FFFF, 32'd1, BLTU, 0, 32'h108);
        issue(1, 0, 32'h10C, 32'd0, 32'd0,         BGEU, 1, 32'h10C);
        // Saturate entry for 0x40 upward, then downward.
        repeat (4) issue(1, 0, 32'h40, 32'd1, 32'd2, BNE, 1, 32'h40);
        repeat (5) issue(1, 0, 32'h40, 32'd7, 32'd7, BNE, 0, 32'h40);
        // 0x140 aliases 0x40 in a 64-entry table.
        repeat (2) issue(1, 0, 32'h140, 32'd3, 32'd3, BEQ, 0, 32'h40);
        issue(1, 0, 32'h40, 32'd3, 32'd3, BEQ, 1, 32'h140);
        // JAL, reserved funct3, stalled and invalid branches.
        issue(1, 0, 32'h40, 32'd1, 32'd2, JAL, 0, 32'h40);
        issue(1, 0, 32'h40, 32'd1, 32'd1, 4'b1011, 1, 32'h40);
        issue(1, 1, 32'h40, 32'd9, 32'd9, BEQ, 0, 32'h40);
        issue(0, 0, 32'h40, 32'd9, 32'd9, BEQ, 0, 32'h40);
        issue(1, 0, 32'h40, 32'd9, 32'd9, 4'b0000, 0, 32'h40);
        // Twenty mispredicted branches saturate the 4-bit counters.
        repeat (20) issue(1, 0, 32'h40, 32'd4, 32'd4, BEQ, 0, 32'h40);

        // Asynchronous reset between edges with the 0x40 entry at 11.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h40, 32'd0, 32'd0, 4'h0, 1'b0, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 0, 32'h40, 32'd4, 32'd4, BEQ, 0, 32'h40);

        for (int n = 0; n < 400; n++) begin
            d1  = $urandom;
            if ($urandom_range(0, 3) == 0) d1 = 32'($urandom_range(0, 7)) - 32'd4;
            d2  = ($urandom_range(0, 1) == 0) ? d1 : $urandom;
            if ($urandom_range(0, 3) == 0) d2 = 32'($urandom_range(0, 7)) - 32'd4;
            sel = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, 3'($urandom)};
            pe  = $urandom & 32'h0000_03FC;
            pi  = ($urandom_range(0, 1) == 0) ? pe : ($urandom & 32'h0000_03FC);
            issue($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                  pe, d1, d2, sel, 1'($urandom), pi);
        end

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
